// File: rtl/loss_batch_monitor.sv
// loss_batch_monitor
// Accumulates per-sample losses over a power-of-two batch, reports the
// truncated batch mean, tracks the best (minimum) mean of the run and
// declares convergence after PATIENCE consecutive batches whose mean is
// at or below the threshold. A run also ends, unconverged, on reaching
// MAX_BATCHES.
module loss_batch_monitor #(
    parameter int LOSS_W      = 42,
    parameter int LOG2_BATCH  = 3,
    parameter int PATIENCE    = 2,
    parameter int MAX_BATCHES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              loss_valid_i,
    input  logic [LOSS_W-1:0] loss_i,
    output logic              loss_ready_o,
    input  logic [LOSS_W-1:0] thresh_i,
    output logic              mean_valid_o,
    output logic [LOSS_W-1:0] mean_o,
    output logic [LOSS_W-1:0] best_o,
    output logic [15:0]       batch_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              converged_o
);

    // Sum is wide enough for a full batch of maximum losses, so it never wraps.
    localparam int SUM_W = LOSS_W + LOG2_BATCH;
    localparam int CNT_W = (LOG2_BATCH < 1) ? 1 : LOG2_BATCH;
    // Patience never exceeds PATIENCE because reaching it ends the run.
    localparam int PAT_W = (PATIENCE < 1) ? 1 : $clog2(PATIENCE + 1);

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_BATCH) - 1);
    localparam logic [PAT_W-1:0] PAT_LIMIT   = PAT_W'(PATIENCE);
    localparam logic [15:0]      BATCH_LIMIT = 16'(MAX_BATCHES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [SUM_W-1:0]  sum_reg, sum_next;
    logic [CNT_W-1:0]  sample_cnt_reg, sample_cnt_next;
    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [15:0]       batch_cnt_reg, batch_cnt_next;
    logic [LOSS_W-1:0] mean_reg, mean_next;
    logic [LOSS_W-1:0] best_reg, best_next;
    logic              mean_valid_reg, mean_valid_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              converged_reg, converged_next;

    // Truncating divide by the batch size is just dropping the low sum bits.
    logic [LOSS_W-1:0] batch_mean;
    assign batch_mean = sum_reg[SUM_W-1:LOG2_BATCH];

    // Ready is decoded from the state register only, so it has no input path.
    assign loss_ready_o = (state_reg == ACCUM);

    assign mean_valid_o = mean_valid_reg;
    assign mean_o       = mean_reg;
    assign best_o       = best_reg;
    assign batch_cnt_o  = batch_cnt_reg;
    assign busy_o       = busy_reg;
    assign done_o       = done_reg;
    assign converged_o  = converged_reg;

    // State and datapath registers; reset discards any partial batch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            sum_reg        <= '0;
            sample_cnt_reg <= '0;
            pat_reg        <= '0;
            batch_cnt_reg  <= '0;
            mean_reg       <= '0;
            best_reg       <= '1;
            mean_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            converged_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sum_reg        <= sum_next;
            sample_cnt_reg <= sample_cnt_next;
            pat_reg        <= pat_next;
            batch_cnt_reg  <= batch_cnt_next;
            mean_reg       <= mean_next;
            best_reg       <= best_next;
            mean_valid_reg <= mean_valid_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            converged_reg  <= converged_next;
        end
    end

    // Next-state and next-output logic; start_i overrides every state,
    // which also drops a coincident sample and suppresses a coincident report.
    always_comb begin
        state_next      = state_reg;
        sum_next        = sum_reg;
        sample_cnt_next = sample_cnt_reg;
        pat_next        = pat_reg;
        batch_cnt_next  = batch_cnt_reg;
        mean_next       = mean_reg;
        best_next       = best_reg;
        mean_valid_next = 1'b0;
        busy_next       = busy_reg;
        done_next       = done_reg;
        converged_next  = converged_reg;

        if (start_i) begin
            state_next      = ACCUM;
            sum_next        = '0;
            sample_cnt_next = '0;
            pat_next        = '0;
            batch_cnt_next  = '0;
            best_next       = '1;
            busy_next       = 1'b1;
            done_next       = 1'b0;
            converged_next  = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (loss_valid_i) begin
                        sum_next        = sum_reg + SUM_W'(loss_i);
                        sample_cnt_next = sample_cnt_reg + CNT_W'(1);
                        if (sample_cnt_reg == LAST_SAMPLE) begin
                            state_next = REPORT;
                        end
                    end
                end
                REPORT: begin
                    mean_next       = batch_mean;
                    mean_valid_next = 1'b1;
                    batch_cnt_next  = batch_cnt_reg + 16'd1;
                    if (batch_mean < best_reg) begin
                        best_next = batch_mean;
                    end
                    if (batch_mean <= thresh_i) begin
                        pat_next = pat_reg + PAT_W'(1);
                    end else begin
                        pat_next = '0;
                    end
                    sum_next        = '0;
                    sample_cnt_next = '0;
                    // Convergence is tested first so it wins over the batch limit.
                    if (pat_next == PAT_LIMIT) begin
                        state_next     = DONE;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                        converged_next = 1'b1;
                    end else if (batch_cnt_next == BATCH_LIMIT) begin
                        state_next     = DONE;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                        converged_next = 1'b0;
                    end else begin
                        state_next = ACCUM;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loss_batch_monitor.sv
// Randomized bench for loss_batch_monitor. A behavioural model keeps the
// accepted samples of the current batch in a queue and computes means with
// plain arithmetic; every cycle the DUT outputs are compared to it.
module tb_loss_batch_monitor;

    localparam int LW       = 42;
    localparam int BATCH    = 8;
    localparam int PAT      = 2;
    localparam int MAXB     = 16;
    localparam logic [LW-1:0] ALL1 = {LW{1'b1}};

    localparam int P_IDLE = 0, P_ACC = 1, P_REP = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          loss_valid_i = 1'b0;
    logic [LW-1:0] loss_i = '0;
    logic [LW-1:0] thresh_i = '0;
    logic          loss_ready_o;
    logic          mean_valid_o;
    logic [LW-1:0] mean_o;
    logic [LW-1:0] best_o;
    logic [15:0]   batch_cnt_o;
    logic          busy_o, done_o, converged_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_phase;
    logic [LW-1:0] m_q[$];
    logic [LW-1:0] m_mean, m_best;
    int            m_cnt, m_pat;
    logic          m_mv, m_busy, m_done, m_conv;

    loss_batch_monitor #(
        .LOSS_W(LW), .LOG2_BATCH(3), .PATIENCE(PAT), .MAX_BATCHES(MAXB)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .loss_valid_i(loss_valid_i), .loss_i(loss_i), .loss_ready_o(loss_ready_o),
        .thresh_i(thresh_i), .mean_valid_o(mean_valid_o), .mean_o(mean_o),
        .best_o(best_o), .batch_cnt_o(batch_cnt_o), .busy_o(busy_o),
        .done_o(done_o), .converged_o(converged_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_q.delete();
        m_mean = '0; m_best = ALL1;
        m_cnt = 0; m_pat = 0;
        m_mv = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_conv = 1'b0;
    endtask

    // Model of one rising edge given the inputs present before it.
    task automatic model_edge(input logic st, input logic vl, input logic [LW-1:0] ls);
        longint unsigned s;
        logic [LW-1:0] m;
        m_mv = 1'b0;
        if (st) begin
            m_q.delete();
            m_cnt = 0; m_best = ALL1; m_pat = 0;
            m_done = 1'b0; m_conv = 1'b0; m_busy = 1'b1;
            m_phase = P_ACC;
        end else if (m_phase == P_ACC) begin
            if (vl) begin
                m_q.push_back(ls);
                if (m_q.size() == BATCH) m_phase = P_REP;
            end
        end else if (m_phase == P_REP) begin
            s = 0;
            foreach (m_q[i]) s += 64'(m_q[i]);
            m = LW'(s / BATCH);
            m_mean = m;
            m_mv = 1'b1;
            m_cnt++;
            if (m < m_best) m_best = m;
            if (m <= thresh_i) m_pat++; else m_pat = 0;
            m_q.delete();
            if (m_pat == PAT) begin
                m_phase = P_DONE; m_done = 1'b1; m_conv = 1'b1; m_busy = 1'b0;
            end else if (m_cnt == MAXB) begin
                m_phase = P_DONE; m_done = 1'b1; m_conv = 1'b0; m_busy = 1'b0;
            end else begin
                m_phase = P_ACC;
            end
            $display("batch %0d: mean=%0d best=%0d patience=%0d", m_cnt, m_mean, m_best, m_pat);
        end
    endtask

    task automatic compare_all();
        check_eq("mean_valid", 64'(mean_valid_o), 64'(m_mv));
        check_eq("mean", 64'(mean_o), 64'(m_mean));
        check_eq("best", 64'(best_o), 64'(m_best));
        check_eq("batch_cnt", 64'(batch_cnt_o), 64'(m_cnt));
        check_eq("busy", 64'(busy_o), 64'(m_busy));
        check_eq("done", 64'(done_o), 64'(m_done));
        check_eq("converged", 64'(converged_o), 64'(m_conv));
    endtask

    // One clock cycle: drive at the falling edge, check ready before the
    // rising edge, advance the model, then check outputs just after it.
    task automatic step(input logic st, input logic vl, input logic [LW-1:0] ls);
        @(negedge clk);
        start_i = st; loss_valid_i = vl; loss_i = ls;
        #1;
        check_eq("ready", 64'(loss_ready_o), 64'(m_phase == P_ACC));
        @(posedge clk);
        model_edge(st, vl, ls);
        #1;
        compare_all();
    endtask

    task automatic send_sample(input logic [LW-1:0] v);
        logic taken;
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, LW'($urandom));
        taken = 1'b0;
        for (int t = 0; t < 20 && !taken; t++) begin
            taken = (m_phase == P_ACC);
            step(1'b0, 1'b1, v);
        end
        check_eq("send_accepted", 64'(taken), 64'(1));
    endtask

    // Eight samples of one value, then the report cycle with a junk offer.
    task automatic batch_const(input logic [LW-1:0] v);
        repeat (BATCH) send_sample(v);
        step(1'b0, 1'($urandom), LW'($urandom));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        start_i = 1'b0; loss_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1 model_reset();
        compare_all();
        check_eq("rst_ready", 64'(loss_ready_o), 64'(0));
        check_eq("rst_best", 64'(best_o), 64'(ALL1));
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] v;
        model_reset();
        #12;
        compare_all();
        check_eq("init_ready", 64'(loss_ready_o), 64'(0));
        @(negedge clk);
        rst_i = 1'b0;

        // Reset in the middle of a batch
        step(1'b1, 1'b0, '0);
        repeat (5) send_sample(42'd7);
        pulse_reset();

        // Basic batch with gaps
        step(1'b1, 1'b0, '0);
        batch_const(42'd10);
        check_eq("basic_mv", 64'(mean_valid_o), 64'(1));
        check_eq("basic_mean", 64'(mean_o), 64'(10));
        check_eq("basic_best", 64'(best_o), 64'(10));
        check_eq("basic_cnt", 64'(batch_cnt_o), 64'(1));

        // Truncation and extremes
        repeat (7) send_sample(42'd1);
        send_sample(42'd0);
        step(1'b0, 1'b0, '0);
        check_eq("trunc_mean", 64'(mean_o), 64'(0));
        batch_const(ALL1);
        check_eq("max_mean", 64'(mean_o), 64'(ALL1));
        check_eq("max_best", 64'(best_o), 64'(0));

        // Convergence with a patience reset in between
        thresh_i = 42'd5;
        step(1'b1, 1'b0, '0);
        batch_const(42'd4);
        batch_const(42'd9);
        batch_const(42'd4);
        batch_const(42'd5);
        check_eq("conv_done", 64'(done_o), 64'(1));
        check_eq("conv_flag", 64'(converged_o), 64'(1));
        check_eq("conv_best", 64'(best_o), 64'(4));
        check_eq("conv_cnt", 64'(batch_cnt_o), 64'(4));
        repeat (5) step(1'b0, 1'b1, 42'd1);
        check_eq("conv_hold_ready", 64'(loss_ready_o), 64'(0));

        // Batch limit without convergence
        thresh_i = '0;
        step(1'b1, 1'b0, '0);
        for (int b = 0; b < MAXB; b++) begin
            repeat (BATCH) send_sample(LW'($urandom_range(8, 1000)));
            step(1'b0, 1'b0, '0);
        end
        check_eq("limit_done", 64'(done_o), 64'(1));
        check_eq("limit_conv", 64'(converged_o), 64'(0));
        check_eq("limit_cnt", 64'(batch_cnt_o), 64'(MAXB));

        // Abort mid-batch with a coincident sample
        step(1'b1, 1'b0, '0);
        batch_const(LW'($urandom_range(0, 500)));
        repeat (5) send_sample(42'd20);
        step(1'b1, 1'b1, 42'd1000);
        check_eq("abort_cnt", 64'(batch_cnt_o), 64'(0));
        check_eq("abort_best", 64'(best_o), 64'(ALL1));
        batch_const(42'd3);
        check_eq("abort_mean", 64'(mean_o), 64'(3));
        check_eq("abort_cnt2", 64'(batch_cnt_o), 64'(1));

        // Random runs with occasional restarts, including during REPORT
        for (int r = 0; r < 5; r++) begin
            thresh_i = LW'($urandom_range(0, 100));
            step(1'b1, 1'b0, '0);
            for (int c = 0; c < 500 && m_phase != P_DONE; c++) begin
                v = LW'($urandom_range(0, 150));
                if (m_phase == P_REP && $urandom_range(0, 7) == 0)
                    step(1'b1, 1'b1, v);
                else
                    step(($urandom_range(0, 79) == 0), 1'($urandom), v);
            end
        end
        repeat (3) step(1'b0, 1'b1, 42'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
